ancho_ramp_ctrl: RTL and testbench
==================================

ANCHO_RAMP_CTRL -- requirements
Module: ancho_ramp_ctrl

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 256, clock cycles between successive speed steps (legal range 1..65535).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port run  input  1  level request to drive the motor PWM; 0 = ramp down and stop.
REQ-005 SHALL have port target_speed  input  3  requested speed code, sampled every cycle.
REQ-006 SHALL have port fault  input  1  level stop request; highest priority after reset.
REQ-007 SHALL have port speed  output  3  registered speed code for the ancho PWM core speed input.
REQ-008 SHALL have port pwm_enable  output  1  registered enable for the ancho PWM core.
REQ-009 SHALL have port busy  output  1  high in RAMP_UP or RAMP_DOWN.
REQ-010 SHALL have port at_target  output  1  high in HOLD.
REQ-011 SHALL have port fault_latched  output  1  high in FAULT.

Function
REQ-012 SHALL implement FSM states IDLE, RAMP_UP, HOLD, RAMP_DOWN, FAULT; busy/at_target/fault_latched decoded from registered state only.
REQ-013 SHALL define eff_target = run ? target_speed : 0, evaluated combinationally each cycle.
REQ-014 SHALL keep a step counter 0..STEP_CYCLES-1, cleared on every state change; a step fires on the cycle it equals STEP_CYCLES-1, counter then wraps to 0.
REQ-015 IDLE: speed=0, pwm_enable=0; if eff_target>0 -> RAMP_UP next edge with pwm_enable=1, speed=0; eff_target=0 -> stay.
REQ-016 RAMP_UP: on step, speed+1; if new speed==eff_target, same edge -> HOLD.
REQ-017 RAMP_UP: if eff_target<speed (any cycle) -> RAMP_DOWN next edge, speed unchanged, counter cleared; eff_target==speed without step -> HOLD.
REQ-018 HOLD: eff_target>speed -> RAMP_UP; eff_target<speed -> RAMP_DOWN; counter cleared; speed unchanged on transition.
REQ-019 RAMP_DOWN: on step, speed-1; if new speed==eff_target: eff_target=0 -> IDLE with pwm_enable=0 same edge, else -> HOLD.
REQ-020 RAMP_DOWN: eff_target>speed -> RAMP_UP next edge, counter cleared; speed==eff_target without step: 0 -> IDLE (pwm_enable=0), else HOLD.
REQ-021 speed SHALL never wrap: no increment past 7, no decrement below 0.
REQ-022 fault=1 in any state SHALL force FAULT next edge: speed=0, pwm_enable=0, counter cleared (no ramp).
REQ-023 FAULT SHALL persist while fault=1 or run=1; exits to IDLE on first edge with fault=0 and run=0.
REQ-024 STEP_CYCLES=1 SHALL step every cycle in ramp states.
REQ-025 pwm_enable SHALL be 1 in RAMP_UP, HOLD, RAMP_DOWN and 0 in IDLE, FAULT.

Reset
REQ-026 reset=1 SHALL on next edge force IDLE, speed=0, pwm_enable=0, counter=0, busy=0, at_target=0, fault_latched=0, overriding fault and run.
REQ-027 reset asserted mid-ramp SHALL stop immediately (no ramp-down); after release FSM restarts from IDLE per REQ-015.

Verification (STEP_CYCLES=4)
REQ-028 Soft start: reset, then run=1, target=3 -> pwm_enable=1 one edge later, speed 1/2/3 at +4/+8/+12 edges after entering RAMP_UP, at_target=1 with speed=3.
REQ-029 Soft stop: from HOLD speed=3, run=0 -> speed 2/1/0 at 4-cycle steps, IDLE and pwm_enable=0 on same edge speed reaches 0.
REQ-030 Reversal: RAMP_UP at speed=2 toward 5, target changes to 1 -> RAMP_DOWN next edge, speed=1 four cycles later, HOLD.
REQ-031 Fault: HOLD speed=6, fault pulse 1 cycle with run=1 -> next edge speed=0, pwm_enable=0, fault_latched=1; stays until run=0, then IDLE.
REQ-032 Reset mid-ramp: RAMP_UP speed=2, reset 1 cycle -> speed=0, IDLE; run still 1, target=2 -> re-ramps from 0.
REQ-033 Limits: target=7, run=1 -> speed ends at 7 in HOLD; target=0 with run=1 from IDLE -> remains IDLE, pwm_enable=0.

Source files
------------

// File: rtl/ancho_ramp_ctrl.sv
// Soft-start/soft-stop ramp controller feeding the ancho PWM core speed and enable inputs.
// Latency: a speed step fires every STEP_CYCLES clocks while ramping; fault and reset take effect on the next edge.
// Backpressure: none; run/target_speed/fault are level inputs, so the controller simply tracks them.
//
// Ports:
//   clock          single clock, all state on its rising edge
//   reset          synchronous active-high reset, overrides everything
//   run            level request to drive the motor; 0 ramps down and stops
//   target_speed   requested 3-bit speed code, sampled every cycle
//   fault          level stop request, forces an immediate stop
//   speed          registered speed code to the PWM core
//   pwm_enable     registered PWM core enable
//   busy           high while ramping up or down
//   at_target      high while holding at the requested speed
//   fault_latched  high while stopped on a fault
module ancho_ramp_ctrl #(
    parameter int STEP_CYCLES = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [2:0] target_speed,
    input  logic       fault,
    output logic [2:0] speed,
    output logic       pwm_enable,
    output logic       busy,
    output logic       at_target,
    output logic       fault_latched
);

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN,
        FAULT
    } state_t;

    localparam logic [15:0] STEP_LAST = 16'(STEP_CYCLES - 1);

    state_t      state;
    logic [15:0] step_cnt;
    logic [2:0]  eff_target;
    logic        step;
    logic [2:0]  speed_inc;
    logic [2:0]  speed_dec;

    // Dropping run is treated as a request for speed zero, so stopping is just a ramp to 0.
    assign eff_target = run ? target_speed : 3'd0;
    assign step       = (step_cnt == STEP_LAST);

    // Only used when speed is strictly below/above eff_target, so neither can wrap.
    assign speed_inc  = speed + 3'd1;
    assign speed_dec  = speed - 3'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            speed      <= 3'd0;
            pwm_enable <= 1'b0;
            step_cnt   <= 16'd0;
        end else if (fault) begin
            state      <= FAULT;
            speed      <= 3'd0;
            pwm_enable <= 1'b0;
            step_cnt   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    speed    <= 3'd0;
                    step_cnt <= 16'd0;
                    if (eff_target != 3'd0) begin
                        state      <= RAMP_UP;
                        pwm_enable <= 1'b1;
                    end else begin
                        pwm_enable <= 1'b0;
                    end
                end

                RAMP_UP: begin
                    // A lowered target reverses immediately, even on a step cycle.
                    if (eff_target < speed) begin
                        state    <= RAMP_DOWN;
                        step_cnt <= 16'd0;
                    end else if (eff_target == speed) begin
                        state    <= HOLD;
                        step_cnt <= 16'd0;
                    end else if (step) begin
                        speed    <= speed_inc;
                        step_cnt <= 16'd0;
                        if (speed_inc == eff_target) begin
                            state <= HOLD;
                        end
                    end else begin
                        step_cnt <= step_cnt + 16'd1;
                    end
                end

                HOLD: begin
                    step_cnt <= 16'd0;
                    if (eff_target > speed) begin
                        state <= RAMP_UP;
                    end else if (eff_target < speed) begin
                        state <= RAMP_DOWN;
                    end
                end

                RAMP_DOWN: begin
                    if (eff_target > speed) begin
                        state    <= RAMP_UP;
                        step_cnt <= 16'd0;
                    end else if (eff_target == speed) begin
                        step_cnt <= 16'd0;
                        if (eff_target == 3'd0) begin
                            state      <= IDLE;
                            pwm_enable <= 1'b0;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (step) begin
                        speed    <= speed_dec;
                        step_cnt <= 16'd0;
                        // Reaching zero drops the enable on the same edge as the last step.
                        if (speed_dec == eff_target) begin
                            if (eff_target == 3'd0) begin
                                state      <= IDLE;
                                pwm_enable <= 1'b0;
                            end else begin
                                state <= HOLD;
                            end
                        end
                    end else begin
                        step_cnt <= step_cnt + 16'd1;
                    end
                end

                FAULT: begin
                    speed      <= 3'd0;
                    pwm_enable <= 1'b0;
                    step_cnt   <= 16'd0;
                    // fault is already low here; run must also drop before restarting.
                    if (!run) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state      <= IDLE;
                    speed      <= 3'd0;
                    pwm_enable <= 1'b0;
                    step_cnt   <= 16'd0;
                end
            endcase
        end
    end

    assign busy          = (state == RAMP_UP) || (state == RAMP_DOWN);
    assign at_target     = (state == HOLD);
    assign fault_latched = (state == FAULT);

endmodule

// File: tb/tb_ancho_ramp_ctrl.sv
// Self-checking bench for ancho_ramp_ctrl with STEP_CYCLES=4.
// Latency: not applicable; outputs compared every falling edge against a behavioural model.
// Backpressure: not applicable.
module tb_ancho_ramp_ctrl;

    localparam int STEP = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic [2:0] target_speed;
    logic       fault;
    logic [2:0] speed;
    logic       pwm_enable;
    logic       busy;
    logic       at_target;
    logic       fault_latched;

    int checks = 0;
    int errors = 0;

    ancho_ramp_ctrl #(.STEP_CYCLES(STEP)) dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .target_speed (target_speed),
        .fault        (fault),
        .speed        (speed),
        .pwm_enable   (pwm_enable),
        .busy         (busy),
        .at_target    (at_target),
        .fault_latched(fault_latched)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the motor is described by its speed, whether the
    // PWM is on, whether a fault stop is latched, and the direction it is
    // currently moving in (+1 up, -1 down, 0 settled). A speed change needs
    // STEP uninterrupted cycles moving in the same direction.
    int m_spd = 0;
    int m_en  = 0;
    int m_flt = 0;
    int m_tmr = 0;
    int m_dir = 0;
    bit started = 1'b0;

    always @(posedge clock) begin
        int eff;
        int want;
        eff = run ? int'(target_speed) : 0;
        if (reset) begin
            m_spd = 0; m_en = 0; m_flt = 0; m_tmr = 0; m_dir = 0;
        end else if (fault) begin
            m_spd = 0; m_en = 0; m_flt = 1; m_tmr = 0; m_dir = 0;
        end else if (m_flt != 0) begin
            if (!run) m_flt = 0;
        end else if (m_en == 0) begin
            if (eff > 0) begin
                m_en = 1; m_dir = 1; m_tmr = 0;
            end
        end else begin
            want = (eff > m_spd) ? 1 : ((eff < m_spd) ? -1 : 0);
            if (want != m_dir) begin
                // Settling at zero while coming down is a full stop.
                if (want == 0 && m_dir == -1 && m_spd == 0) m_en = 0;
                m_dir = want;
                m_tmr = 0;
            end else if (want != 0) begin
                m_tmr++;
                if (m_tmr == STEP) begin
                    m_tmr = 0;
                    m_spd = m_spd + want;
                    if (m_spd == eff) begin
                        if (m_dir == -1 && m_spd == 0) m_en = 0;
                        m_dir = 0;
                    end
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clock) begin
        if (started) begin
            chk("model_speed",         8'(speed),         8'(m_spd));
            chk("model_pwm_enable",    8'(pwm_enable),    8'(m_en));
            chk("model_busy",          8'(busy),          8'(m_en != 0 && m_dir != 0));
            chk("model_at_target",     8'(at_target),     8'(m_en != 0 && m_dir == 0));
            chk("model_fault_latched", 8'(fault_latched), 8'(m_flt));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; target_speed = 3'd0; fault = 1'b0;
        tick(2);
        chk("reset_speed",  8'(speed), 8'd0);
        chk("reset_pwm",    8'(pwm_enable), 8'd0);
        chk("reset_busy",   8'(busy), 8'd0);
        chk("reset_attgt",  8'(at_target), 8'd0);
        chk("reset_flt",    8'(fault_latched), 8'd0);

        // Zero target with run=1 stays idle.
        reset = 1'b0; run = 1'b1; target_speed = 3'd0;
        tick(3);
        chk("zero_tgt_pwm",   8'(pwm_enable), 8'd0);
        chk("zero_tgt_speed", 8'(speed), 8'd0);

        // Soft start to 3.
        target_speed = 3'd3;
        tick(1);
        chk("start_pwm",   8'(pwm_enable), 8'd1);
        chk("start_speed", 8'(speed), 8'd0);
        chk("start_busy",  8'(busy), 8'd1);
        tick(3);
        chk("start_pre1",  8'(speed), 8'd0);
        tick(1);
        chk("start_s1",    8'(speed), 8'd1);
        tick(4);
        chk("start_s2",    8'(speed), 8'd2);
        tick(4);
        chk("start_s3",    8'(speed), 8'd3);
        chk("start_hold",  8'(at_target), 8'd1);
        chk("start_nbusy", 8'(busy), 8'd0);

        // Soft stop from 3.
        run = 1'b0;
        tick(1);
        chk("stop_busy",   8'(busy), 8'd1);
        chk("stop_s3",     8'(speed), 8'd3);
        tick(4);
        chk("stop_s2",     8'(speed), 8'd2);
        tick(4);
        chk("stop_s1",     8'(speed), 8'd1);
        tick(3);
        chk("stop_pwm_on", 8'(pwm_enable), 8'd1);
        tick(1);
        chk("stop_s0",     8'(speed), 8'd0);
        chk("stop_pwm",    8'(pwm_enable), 8'd0);
        chk("stop_idle",   8'(busy), 8'd0);

        // Reversal while ramping toward 5.
        run = 1'b1; target_speed = 3'd5;
        tick(9);
        chk("rev_s2",      8'(speed), 8'd2);
        chk("rev_busy",    8'(busy), 8'd1);
        target_speed = 3'd1;
        tick(1);
        chk("rev_down_s2", 8'(speed), 8'd2);
        chk("rev_down_bz", 8'(busy), 8'd1);
        tick(3);
        chk("rev_pre",     8'(speed), 8'd2);
        tick(1);
        chk("rev_s1",      8'(speed), 8'd1);
        chk("rev_hold",    8'(at_target), 8'd1);

        // Fault from HOLD at 6.
        target_speed = 3'd6;
        tick(21);
        chk("flt_s6",      8'(speed), 8'd6);
        chk("flt_hold",    8'(at_target), 8'd1);
        fault = 1'b1;
        tick(1);
        fault = 1'b0;
        chk("flt_speed",   8'(speed), 8'd0);
        chk("flt_pwm",     8'(pwm_enable), 8'd0);
        chk("flt_latched", 8'(fault_latched), 8'd1);
        tick(3);
        chk("flt_persist", 8'(fault_latched), 8'd1);
        run = 1'b0;
        tick(1);
        chk("flt_exit",    8'(fault_latched), 8'd0);
        chk("flt_exit_pw", 8'(pwm_enable), 8'd0);

        // Reset mid-ramp, then re-ramp from 0 to 2.
        run = 1'b1; target_speed = 3'd5;
        tick(9);
        chk("rst_s2",      8'(speed), 8'd2);
        reset = 1'b1; target_speed = 3'd2;
        tick(1);
        chk("rst_speed",   8'(speed), 8'd0);
        chk("rst_pwm",     8'(pwm_enable), 8'd0);
        chk("rst_busy",    8'(busy), 8'd0);
        reset = 1'b0;
        tick(1);
        chk("rst_restart", 8'(pwm_enable), 8'd1);
        tick(4);
        chk("rst_s1",      8'(speed), 8'd1);
        tick(4);
        chk("rst_s2b",     8'(speed), 8'd2);
        chk("rst_hold",    8'(at_target), 8'd1);

        // Top limit.
        target_speed = 3'd7;
        tick(21);
        chk("lim_s7",      8'(speed), 8'd7);
        chk("lim_hold",    8'(at_target), 8'd1);
        tick(6);
        chk("lim_stay",    8'(speed), 8'd7);

        // Reset beats fault.
        reset = 1'b1; fault = 1'b1;
        tick(1);
        chk("rstflt_flt",  8'(fault_latched), 8'd0);
        chk("rstflt_spd",  8'(speed), 8'd0);
        reset = 1'b0;
        tick(1);
        chk("rstflt_lat",  8'(fault_latched), 8'd1);
        fault = 1'b0; run = 1'b0;
        tick(1);
        chk("rstflt_exit", 8'(fault_latched), 8'd0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
